pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline.
- Decodes load-use hazards, taken branches and multi-cycle data-memory accesses.
- Drives the hold, flush and bubble controls of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- MEM_WB_enable follows the existing register convention: 0 = capture, 1 = bubble.

---
 rtl/pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and
// multi-cycle data-memory hazards drive hold/flush/bubble controls of every stage.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             MEM_WB_enable,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT  = 8'(MEM_TIMEOUT);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [2:0]       flush_cnt_r;
    logic [2:0]       flush_cnt_nxt_s;
    logic [7:0]       wait_cnt_r;
    logic [7:0]       wait_cnt_nxt_s;
    logic             mem_timeout_r;
    logic             timeout_set_s;
    logic [CNT_W-1:0] stall_count_r;
    logic             mem_stall_s;
    logic             load_use_s;

    assign mem_stall_s = mem_access & ~mem_ready;
    assign load_use_s  = ex_mem_read & (ex_rt != 5'd0) &
                         ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    assign mem_timeout = mem_timeout_r;
    assign stall_count = stall_count_r;

    // Output decode and next-state selection
    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        id_ex_hold      = 1'b0;
        ex_mem_hold     = 1'b0;
        MEM_WB_enable   = 1'b0;
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        wait_cnt_nxt_s  = wait_cnt_r;
        timeout_set_s   = 1'b0;
        if (!reset_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            MEM_WB_enable = 1'b1;
            state_nxt_s   = ST_RUN;
        end else begin
            case (state_r)
                ST_MEM_WAIT: begin
                    if (mem_ready || (wait_cnt_r == WAIT_LIMIT)) begin
                        // Release: EX resumes, so branch and load-use are evaluated afresh
                        if (branch_taken) begin
                            if_id_flush  = 1'b1;
                            id_ex_bubble = 1'b1;
                        end else if (load_use_s) begin
                            pc_write     = 1'b0;
                            if_id_write  = 1'b0;
                            id_ex_bubble = 1'b1;
                        end else begin
                            pc_write     = 1'b1;
                        end
                        MEM_WB_enable  = ~mem_ready;
                        timeout_set_s  = ~mem_ready;
                        state_nxt_s    = ST_RUN;
                        wait_cnt_nxt_s = 8'd0;
                    end else begin
                        pc_write       = 1'b0;
                        if_id_write    = 1'b0;
                        id_ex_hold     = 1'b1;
                        ex_mem_hold    = 1'b1;
                        MEM_WB_enable  = 1'b1;
                        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                    end
                end
                ST_FLUSH: begin
                    if (mem_stall_s) begin
                        pc_write        = 1'b0;
                        if_id_write     = 1'b0;
                        id_ex_hold      = 1'b1;
                        ex_mem_hold     = 1'b1;
                        MEM_WB_enable   = 1'b1;
                        state_nxt_s     = ST_MEM_WAIT;
                        wait_cnt_nxt_s  = 8'd1;
                        flush_cnt_nxt_s = 3'd0;
                    end else begin
                        if_id_flush     = 1'b1;
                        flush_cnt_nxt_s = flush_cnt_r - 3'd1;
                        if (flush_cnt_r <= 3'd1) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_FLUSH;
                        end
                    end
                end
                default: begin
                    if (mem_stall_s) begin
                        pc_write       = 1'b0;
                        if_id_write    = 1'b0;
                        id_ex_hold     = 1'b1;
                        ex_mem_hold    = 1'b1;
                        MEM_WB_enable  = 1'b1;
                        state_nxt_s    = ST_MEM_WAIT;
                        wait_cnt_nxt_s = 8'd1;
                    end else if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt_s     = ST_FLUSH;
                            flush_cnt_nxt_s = FLUSH_INIT;
                        end else begin
                            state_nxt_s     = ST_RUN;
                        end
                    end else if (load_use_s) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else begin
                        state_nxt_s  = ST_RUN;
                    end
                end
            endcase
        end
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_RUN;
            flush_cnt_r   <= 3'd0;
            wait_cnt_r    <= 8'd0;
            mem_timeout_r <= 1'b0;
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            if (timeout_set_s) begin
                mem_timeout_r <= 1'b1;
            end
            if (!pc_write && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
